alu_seq_ctrl: RTL
=================

# alu_seq_ctrl

Command sequencer that drives the team's combinational `alu` from a valid/ready command stream and returns registered results on a valid/ready response stream. It is the initiator end of the ALU operand/result interface. It registers the operands, opcode and carry-in, samples `result` and `zero` one cycle later, and holds a WIDTH-bit accumulator that later commands can use as operand A. It sits between a control source (CPU decode stage or test sequencer) and one `alu` instance.

## Interface
- `WIDTH`, default 8: operand, result and accumulator width.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: sequencer accepts a command.
- `cmd_op` in 3: ALU opcode, passed through unmodified.
- `cmd_cin` in 1: ALU carry-in.
- `cmd_a` in WIDTH: operand A, used when `cmd_use_acc`=0.
- `cmd_b` in WIDTH: operand B.
- `cmd_use_acc` in 1: 1 selects the accumulator as operand A.
- `alu_a` out WIDTH: registered operand A to ALU `A`.
- `alu_b` out WIDTH: registered operand B to ALU `B`.
- `alu_opcode` out 3: registered opcode to ALU `opcode`.
- `alu_cin` out 1: registered carry-in to ALU `c_in`.
- `alu_result` in WIDTH: from ALU `result`.
- `alu_zero` in 1: from ALU `zero`.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_result` out WIDTH: captured ALU result.
- `rsp_zero` out 1: captured ALU zero flag.
- `acc` out WIDTH: accumulator value.
- `op_count` out 16: number of completed responses, wraps.

## Operation
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`&`cmd_ready`, load `alu_a` (= `acc` if `cmd_use_acc`, else `cmd_a`), `alu_b`, `alu_opcode` and `alu_cin`, then go to EXEC.
- EXEC:
  - `cmd_ready`=0.
  - Capture `alu_result` into `rsp_result` and `alu_result` into `acc`. Capture `alu_zero` into `rsp_zero`.
  - Set `rsp_valid`=1 and go to RESP.
- RESP:
  - `rsp_valid`=1. `rsp_result` and `rsp_zero` are held stable.
  - On `rsp_ready`: clear `rsp_valid`, increment `op_count` (modulo 2^16), go to IDLE.
  - Without `rsp_ready`: stay in RESP indefinitely. No command is accepted.
- Operand hold: `alu_*` registers keep their last values outside the load event. The ALU inputs change only when a command is accepted.
- Accumulator:
  - Written only in EXEC and always takes the full WIDTH-bit result; there is no carry-out.
  - `cmd_use_acc` samples `acc` at command acceptance, i.e. the value from the previously completed op.
- The sequencer does not interpret opcodes. It must behave identically for all 8 codes.
- `cmd_valid` while not in IDLE is ignored. The command is taken at the first IDLE cycle in which it is still valid.

## Timing
- Reset (`rst_n`=0 at a rising edge), regardless of state:
  - State becomes IDLE.
  - `cmd_ready`=1 from the first cycle after reset.
  - `alu_a`, `alu_b`, `alu_opcode`, `alu_cin`, `rsp_valid`, `rsp_result`, `rsp_zero`, `acc` and `op_count` all become 0.
  - A pending op or unconsumed response is discarded and not counted.
- `cmd_ready` is a combinational decode of state (IDLE). It does not depend on `cmd_valid`.
- Latency, with the command handshake at edge E0:
  - `alu_*` are valid after E0.
  - `rsp_valid`, `rsp_result`, `rsp_zero` and `acc` update at E1.
  - The earliest response handshake is E2.
  - The next command can be accepted at E3.
  - Peak throughput is one op per 3 cycles.
- The ALU path (`alu_*` reg → ALU → capture reg) must close in one cycle.
- `op_count` increments on the same edge as the response handshake. 0xFFFF wraps to 0x0000.

## Test plan
All scenarios bench `alu_seq_ctrl` connected to a real `alu` #(8).
- Add: cmd op=001, a=10, b=3, cin=0 → `alu_*` loaded 1 cycle after the handshake; `rsp_valid` 2 cycles after the handshake; `rsp_result`=13, `rsp_zero`=0, `acc`=13, `op_count`=1.
- Subtract and accumulate:
  - First op: op=010, a=10, b=3, cin=1 → `rsp_result`=7.
  - Then op=010, use_acc=1, b=7, cin=1 → `rsp_result`=0, `rsp_zero`=1, `acc`=0.
- Back-pressure:
  - AND (op=100) with a=0xAA, b=0x55, and `rsp_ready` held 0 for 5 cycles → `rsp_valid` stays 1 and `rsp_result`=0x00, `rsp_zero`=1 stay stable.
  - `cmd_ready`=0 throughout, and a second `cmd_valid` is ignored until IDLE.
- Logic sweep with `rsp_ready` tied 1:
  - Ops and expected results:
    - OR (op=101), a=0xAA, b=0x55 → 0xFF.
    - XOR (op=110), a=0xAA, b=0xAA → 0x00 with zero=1.
    - NOT (op=111), a=0xFF → 0x00.
  - Expected accept-to-accept spacing is exactly 3 cycles.
- Reset mid-op: assert `rst_n`=0 in EXEC and then again in RESP → next cycle all outputs are 0, `cmd_ready`=1, and `op_count` is unchanged from 0.
- Counter wrap: preload `op_count` to 0xFFFF via 65535 ops with a hierarchical force → the next completed response gives `op_count`=0x0000.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: command sequencer for one combinational ALU.
// It accepts a command, registers the operands for the ALU and captures the
// result one cycle later. It then holds the response until it is consumed.
// A WIDTH-bit accumulator can be used as operand A.
module alu_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic             cmd_cin,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_use_acc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_opcode,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] acc,
  output logic [15:0]      op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic             w_cmd_ready;
  logic             w_accept;
  logic             w_rsp_done;

  logic [WIDTH-1:0] r_alu_a_p0;
  logic [WIDTH-1:0] r_alu_b_p0;
  logic [2:0]       r_alu_op_p0;
  logic             r_alu_cin_p0;
  logic             r_vld_p1;
  logic [WIDTH-1:0] r_rsp_result_p1;
  logic             r_rsp_zero_p1;
  logic [WIDTH-1:0] r_acc;
  logic [15:0]      r_op_count;

  assign w_accept   = cmd_valid & w_cmd_ready;
  assign w_rsp_done = (r_state == RESP) & rsp_ready;

  // State register: reset forces IDLE from any state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode: IDLE -> EXEC on accept, EXEC -> RESP always, RESP -> IDLE on consume.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = EXEC;
      EXEC:    w_next_state = RESP;
      RESP:    if (rsp_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output decode: the command side is ready only in IDLE, regardless of cmd_valid.
  always_comb begin
    w_cmd_ready = 1'b0;
    case (r_state)
      IDLE:    w_cmd_ready = 1'b1;
      default: w_cmd_ready = 1'b0;
    endcase
  end

  // Stage p0: operand registers feeding the ALU; they change only on command acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_alu_a_p0   <= '0;
      r_alu_b_p0   <= '0;
      r_alu_op_p0  <= '0;
      r_alu_cin_p0 <= 1'b0;
    end else if (w_accept) begin
      r_alu_a_p0   <= cmd_use_acc ? r_acc : cmd_a;
      r_alu_b_p0   <= cmd_b;
      r_alu_op_p0  <= cmd_op;
      r_alu_cin_p0 <= cmd_cin;
    end
  end

  // Stage p1: capture the ALU output in EXEC and hold it until the response is consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p1        <= 1'b0;
      r_rsp_result_p1 <= '0;
      r_rsp_zero_p1   <= 1'b0;
      r_acc           <= '0;
      r_op_count      <= '0;
    end else begin
      if (r_state == EXEC) begin
        r_vld_p1        <= 1'b1;
        r_rsp_result_p1 <= alu_result;
        r_rsp_zero_p1   <= alu_zero;
        r_acc           <= alu_result;
      end
      if (w_rsp_done) begin
        r_vld_p1   <= 1'b0;
        r_op_count <= r_op_count + 16'd1;
      end
    end
  end

  assign cmd_ready  = w_cmd_ready;
  assign alu_a      = r_alu_a_p0;
  assign alu_b      = r_alu_b_p0;
  assign alu_opcode = r_alu_op_p0;
  assign alu_cin    = r_alu_cin_p0;
  assign rsp_valid  = r_vld_p1;
  assign rsp_result = r_rsp_result_p1;
  assign rsp_zero   = r_rsp_zero_p1;
  assign acc        = r_acc;
  assign op_count   = r_op_count;

endmodule
